// File: rtl/sblk_conv_row.sv
// One-row convolution engine: loads a window of activation words, runs OW*KW
// signed MACs, then streams OW partial sums; repeats for every tile of the loop nest.
`ifndef ACTBUF_DATA_LEN
`define ACTBUF_DATA_LEN 16
`endif
`ifndef HW_TEMP_PARAM_LEN
`define HW_TEMP_PARAM_LEN 64
`endif

module sblk_conv_row (
    input  logic                            clk_l,
    input  logic                            rst_n,
    input  logic [`HW_TEMP_PARAM_LEN-1:0]   temp_param,
    input  logic                            temp_param_en,
    input  logic [2*`ACTBUF_DATA_LEN-1:0]   actbuf_wr_data,
    input  logic                            actbuf_wr_vld,
    output logic                            actbuf_wr_req,
    output logic                            sblk_status,
    output logic [31:0]                     pbuf_rd_data
);
    typedef enum logic [1:0] {IDLE, LOAD, MAC, OUT} state_t;

    state_t            state;
    logic [7:0][7:0]   cfg;
    logic [16:0]       wr_cnt;
    logic [7:0]        o_cnt, k_cnt, out_cnt;
    logic [31:0]       tile_cnt;
    logic [31:0]       acc;
    logic [31:0]       psum [64];
    logic [2*`ACTBUF_DATA_LEN-1:0] buffer [64];

    logic [7:0]  kw, ow, stride, f4, f5, f6, f7;
    logic [16:0] win_len;
    logic [31:0] tiles;
    logic [5:0]  mac_idx;
    logic signed [`ACTBUF_DATA_LEN-1:0] act_hi, act_lo;
    logic signed [31:0] prod;
    logic [31:0] acc_sum;

    // Zero-valued dimensions and loop counts behave as 1.
    assign kw     = (cfg[0] == 8'd0) ? 8'd1 : cfg[0];
    assign ow     = (cfg[1] == 8'd0) ? 8'd1 : cfg[1];
    assign stride = (cfg[2] == 8'd0) ? 8'd1 : cfg[2];
    assign f4     = (cfg[4] == 8'd0) ? 8'd1 : cfg[4];
    assign f5     = (cfg[5] == 8'd0) ? 8'd1 : cfg[5];
    assign f6     = (cfg[6] == 8'd0) ? 8'd1 : cfg[6];
    assign f7     = (cfg[7] == 8'd0) ? 8'd1 : cfg[7];

    assign win_len = 17'(16'(ow - 8'd1) * 16'(stride)) + 17'(kw);
    assign tiles   = 32'(f4) * 32'(f5) * 32'(f6) * 32'(f7);

    assign actbuf_wr_req = (state == LOAD) &&
                           ((18'(wr_cnt) + 18'(actbuf_wr_vld)) < 18'(win_len));

    // Window index wraps mod 64 when the configured window is oversized.
    assign mac_idx = 6'(16'(o_cnt) * 16'(stride) + 16'(k_cnt));
    assign act_hi  = buffer[mac_idx][2*`ACTBUF_DATA_LEN-1:`ACTBUF_DATA_LEN];
    assign act_lo  = buffer[mac_idx][`ACTBUF_DATA_LEN-1:0];
    assign prod    = act_hi * act_lo;
    assign acc_sum = acc + prod;

    assign pbuf_rd_data = (state == OUT) ? psum[out_cnt[5:0]] : 32'd0;

    always_ff @(posedge clk_l) begin
        if (!temp_param_en && state == LOAD && actbuf_wr_vld && wr_cnt < win_len)
            buffer[wr_cnt[5:0]] <= actbuf_wr_data;
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cfg         <= '0;
            wr_cnt      <= '0;
            o_cnt       <= '0;
            k_cnt       <= '0;
            out_cnt     <= '0;
            tile_cnt    <= '0;
            acc         <= '0;
            sblk_status <= 1'b0;
            for (int i = 0; i < 64; i++) psum[i] <= '0;
        end else begin
            sblk_status <= 1'b0;
            if (temp_param_en) begin
                cfg      <= temp_param;
                wr_cnt   <= '0;
                o_cnt    <= '0;
                k_cnt    <= '0;
                out_cnt  <= '0;
                tile_cnt <= '0;
                acc      <= '0;
                state    <= LOAD;
            end else begin
                case (state)
                    IDLE: ;
                    LOAD: begin
                        if (wr_cnt == win_len) begin
                            state <= MAC;
                            o_cnt <= '0;
                            k_cnt <= '0;
                            acc   <= '0;
                        end else if (actbuf_wr_vld) begin
                            wr_cnt <= wr_cnt + 17'd1;
                        end
                    end
                    MAC: begin
                        // Close out one output at the last tap; acc restarts for the next.
                        if (k_cnt == kw - 8'd1) begin
                            psum[o_cnt[5:0]] <= acc_sum;
                            acc   <= '0;
                            k_cnt <= '0;
                            if (o_cnt == ow - 8'd1) begin
                                state   <= OUT;
                                out_cnt <= '0;
                            end else begin
                                o_cnt <= o_cnt + 8'd1;
                            end
                        end else begin
                            acc   <= acc_sum;
                            k_cnt <= k_cnt + 8'd1;
                        end
                    end
                    OUT: begin
                        if (out_cnt == ow - 8'd1) begin
                            sblk_status <= 1'b1;
                            tile_cnt    <= tile_cnt + 32'd1;
                            wr_cnt      <= '0;
                            state       <= (tile_cnt + 32'd1 < tiles) ? LOAD : IDLE;
                        end else begin
                            out_cnt <= out_cnt + 8'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sblk_conv_row.sv
// Directed bench for sblk_conv_row: one task per scenario, hand-computed expectations.
module tb_sblk_conv_row;
    logic        clk_l = 1'b0;
    logic        rst_n;
    logic [63:0] temp_param;
    logic        temp_param_en;
    logic [31:0] actbuf_wr_data;
    logic        actbuf_wr_vld;
    logic        actbuf_wr_req;
    logic        sblk_status;
    logic [31:0] pbuf_rd_data;

    sblk_conv_row dut (
        .clk_l          (clk_l),
        .rst_n          (rst_n),
        .temp_param     (temp_param),
        .temp_param_en  (temp_param_en),
        .actbuf_wr_data (actbuf_wr_data),
        .actbuf_wr_vld  (actbuf_wr_vld),
        .actbuf_wr_req  (actbuf_wr_req),
        .sblk_status    (sblk_status),
        .pbuf_rd_data   (pbuf_rd_data)
    );

    always #5 clk_l = ~clk_l;

    // P7..P0 packed MSB first
    localparam logic [63:0] CFG_MAIN   = 64'h04_02_07_08_08_02_07_04;
    localparam logic [63:0] CFG_SINGLE = 64'h01_01_01_01_08_02_07_04;
    localparam logic [63:0] CFG_ZERO   = 64'h00_00_00_00_00_00_00_00;

    int checks = 0;
    int failures = 0;

    logic [31:0] words [16];
    logic [31:0] got [7];
    int   zeros;
    logic timeout, status_early, post_status, post_status2, post_req;
    logic [31:0] post_pbuf;
    logic req_first, req_last;

    task automatic load_cfg(input logic [63:0] p);
        temp_param = p;
        temp_param_en = 1'b1;
        @(negedge clk_l);
        temp_param_en = 1'b0;
    endtask

    // Drive n words; gap>0 inserts that many idle cycles after every 5 words.
    task automatic feed(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            if (gap > 0 && i > 0 && i % 5 == 0) begin
                actbuf_wr_vld = 1'b0;
                repeat (gap) @(negedge clk_l);
            end
            actbuf_wr_vld = 1'b1;
            actbuf_wr_data = words[i];
            #1;
            if (i == 0) req_first = actbuf_wr_req;
            if (i == n - 1) req_last = actbuf_wr_req;
            @(negedge clk_l);
        end
        actbuf_wr_vld = 1'b0;
    endtask

    // Records the output stream of one tile; no judgement here.
    task automatic drain(input int n_out);
        zeros = 0;
        timeout = 1'b0;
        status_early = 1'b0;
        while (pbuf_rd_data == 32'd0) begin
            if (sblk_status) status_early = 1'b1;
            zeros++;
            if (zeros > 400) begin
                timeout = 1'b1;
                return;
            end
            @(negedge clk_l);
        end
        for (int j = 0; j < n_out; j++) begin
            got[j] = pbuf_rd_data;
            if (sblk_status) status_early = 1'b1;
            if (j < n_out - 1) @(negedge clk_l);
        end
        @(negedge clk_l);
        post_status = sblk_status;
        post_req    = actbuf_wr_req;
        post_pbuf   = pbuf_rd_data;
        @(negedge clk_l);
        post_status2 = sblk_status;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        temp_param = CFG_MAIN;
        temp_param_en = 1'b0;
        actbuf_wr_vld = 1'b1;
        actbuf_wr_data = 32'h1234_5678;
        repeat (3) @(negedge clk_l);
        checks++; if (actbuf_wr_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", actbuf_wr_req); end
        checks++; if (sblk_status !== 1'b0) begin failures++; $display("FAIL reset_status: got %b want 0", sblk_status); end
        checks++; if (pbuf_rd_data !== 32'd0) begin failures++; $display("FAIL reset_pbuf: got %h want 0", pbuf_rd_data); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk_l);
        checks++; if (actbuf_wr_req !== 1'b0) begin failures++; $display("FAIL idle_req: got %b want 0", actbuf_wr_req); end
        checks++; if (pbuf_rd_data !== 32'd0) begin failures++; $display("FAIL idle_pbuf: got %h want 0", pbuf_rd_data); end
        actbuf_wr_vld = 1'b0;
    endtask

    task automatic test_basic;
        for (int i = 0; i < 16; i++) words[i] = {16'h0001, 16'h0002};
        load_cfg(CFG_MAIN);
        checks++; if (actbuf_wr_req !== 1'b1) begin failures++; $display("FAIL basic_req_load: got %b want 1", actbuf_wr_req); end
        feed(16, 0);
        drain(7);
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL basic_timeout: got %b want 0", timeout); end
        checks++; if (req_first !== 1'b1) begin failures++; $display("FAIL basic_req_first: got %b want 1", req_first); end
        checks++; if (req_last !== 1'b0) begin failures++; $display("FAIL basic_req_last: got %b want 0", req_last); end
        checks++; if (zeros != 29) begin failures++; $display("FAIL basic_latency: got %0d want 29", zeros); end
        for (int j = 0; j < 7; j++) begin
            checks++; if (got[j] !== 32'd8) begin failures++; $display("FAIL basic_psum%0d: got %0d want 8", j, got[j]); end
        end
        checks++; if (status_early !== 1'b0) begin failures++; $display("FAIL basic_status_early: got %b want 0", status_early); end
        checks++; if (post_status !== 1'b1) begin failures++; $display("FAIL basic_status: got %b want 1", post_status); end
        checks++; if (post_status2 !== 1'b0) begin failures++; $display("FAIL basic_status_width: got %b want 0", post_status2); end
        checks++; if (post_pbuf !== 32'd0) begin failures++; $display("FAIL basic_pbuf_after: got %h want 0", post_pbuf); end
        checks++; if (post_req !== 1'b1) begin failures++; $display("FAIL basic_req_again: got %b want 1", post_req); end
    endtask

    task automatic test_ramp;
        for (int i = 0; i < 16; i++) words[i] = {16'(i), 16'h0001};
        load_cfg(CFG_MAIN);
        feed(16, 0);
        drain(7);
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL ramp_timeout: got %b want 0", timeout); end
        checks++; if (zeros != 29) begin failures++; $display("FAIL ramp_latency: got %0d want 29", zeros); end
        for (int j = 0; j < 7; j++) begin
            checks++; if (got[j] !== 32'(8 * j + 6)) begin failures++; $display("FAIL ramp_psum%0d: got %0d want %0d", j, got[j], 8 * j + 6); end
        end
    endtask

    task automatic test_gaps;
        for (int i = 0; i < 16; i++) words[i] = {16'(i), 16'h0001};
        load_cfg(CFG_MAIN);
        feed(16, 5);
        drain(7);
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL gaps_timeout: got %b want 0", timeout); end
        checks++; if (zeros != 29) begin failures++; $display("FAIL gaps_latency: got %0d want 29", zeros); end
        for (int j = 0; j < 7; j++) begin
            checks++; if (got[j] !== 32'(8 * j + 6)) begin failures++; $display("FAIL gaps_psum%0d: got %0d want %0d", j, got[j], 8 * j + 6); end
        end
    endtask

    task automatic test_neg_ones;
        for (int i = 0; i < 16; i++) words[i] = 32'hffff_ffff;
        load_cfg(CFG_MAIN);
        feed(16, 0);
        drain(7);
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL neg_timeout: got %b want 0", timeout); end
        for (int j = 0; j < 7; j++) begin
            checks++; if (got[j] !== 32'd4) begin failures++; $display("FAIL neg_psum%0d: got %0d want 4", j, got[j]); end
        end
    endtask

    task automatic test_single_tile;
        for (int i = 0; i < 16; i++) words[i] = {16'(i), 16'h0001};
        load_cfg(CFG_SINGLE);
        feed(16, 0);
        drain(7);
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL single_timeout: got %b want 0", timeout); end
        checks++; if (got[6] !== 32'd54) begin failures++; $display("FAIL single_psum6: got %0d want 54", got[6]); end
        checks++; if (post_status !== 1'b1) begin failures++; $display("FAIL single_status: got %b want 1", post_status); end
        checks++; if (post_req !== 1'b0) begin failures++; $display("FAIL single_req_idle: got %b want 0", post_req); end
        actbuf_wr_vld = 1'b1;
        actbuf_wr_data = 32'h0005_0005;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++; if (actbuf_wr_req !== 1'b0 || sblk_status !== 1'b0 || pbuf_rd_data !== 32'd0) begin
                failures++;
                $display("FAIL single_idle_c%0d: got req=%b status=%b pbuf=%h want 0/0/0", c, actbuf_wr_req, sblk_status, pbuf_rd_data);
            end
            @(negedge clk_l);
        end
        actbuf_wr_vld = 1'b0;
    endtask

    // All-zero config: KW=OW=stride=1, one tile of one word.
    task automatic test_zero_params;
        words[0] = {16'h0003, 16'hfffb};
        load_cfg(CFG_ZERO);
        feed(1, 0);
        drain(1);
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL zero_timeout: got %b want 0", timeout); end
        checks++; if (req_last !== 1'b0) begin failures++; $display("FAIL zero_req_last: got %b want 0", req_last); end
        checks++; if (zeros != 2) begin failures++; $display("FAIL zero_latency: got %0d want 2", zeros); end
        checks++; if (got[0] !== 32'hffff_fff1) begin failures++; $display("FAIL zero_psum: got %h want fffffff1", got[0]); end
        checks++; if (post_status !== 1'b1) begin failures++; $display("FAIL zero_status: got %b want 1", post_status); end
        checks++; if (post_req !== 1'b0) begin failures++; $display("FAIL zero_req_idle: got %b want 0", post_req); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 16; i++) words[i] = {16'h7777, 16'h0003};
        load_cfg(CFG_MAIN);
        feed(10, 0);
        actbuf_wr_vld = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (actbuf_wr_req !== 1'b0) begin failures++; $display("FAIL rstmid_req: got %b want 0", actbuf_wr_req); end
        checks++; if (pbuf_rd_data !== 32'd0) begin failures++; $display("FAIL rstmid_pbuf: got %h want 0", pbuf_rd_data); end
        @(negedge clk_l);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_l);
        checks++; if (actbuf_wr_req !== 1'b0) begin failures++; $display("FAIL rstmid_idle_req: got %b want 0", actbuf_wr_req); end
        actbuf_wr_vld = 1'b0;
        for (int i = 0; i < 16; i++) words[i] = {16'(i), 16'h0001};
        load_cfg(CFG_MAIN);
        checks++; if (actbuf_wr_req !== 1'b1) begin failures++; $display("FAIL rstmid_req_reload: got %b want 1", actbuf_wr_req); end
        feed(16, 0);
        drain(7);
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL rstmid_timeout: got %b want 0", timeout); end
        checks++; if (zeros != 29) begin failures++; $display("FAIL rstmid_latency: got %0d want 29", zeros); end
        for (int j = 0; j < 7; j++) begin
            checks++; if (got[j] !== 32'(8 * j + 6)) begin failures++; $display("FAIL rstmid_psum%0d: got %0d want %0d", j, got[j], 8 * j + 6); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ramp();
        test_gaps();
        test_neg_ones();
        test_single_tile();
        test_zero_params();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sblk_conv_row.md
SBLK_CONV_ROW -- requirements
Module: sblk_conv_row

Interface
REQ-001 Macro ACTBUF_DATA_LEN, 16, width of one signed activation half-word.
REQ-002 Macro HW_TEMP_PARAM_LEN, 64, width of temp_param; field HW_TEMP_PARAMi (i=0..7) occupies bits [8i+7:8i], unsigned.
REQ-003 Single clock and reset: clk_l is the only clock; rst_n is asynchronous, active-low.
REQ-004 clk_l  in  1  clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 temp_param  in  64  packed configuration P0..P7.
REQ-007 temp_param_en  in  1  one-cycle config load strobe.
REQ-008 actbuf_wr_data  in  32  {act_hi[31:16], act_lo[15:0]}, both signed 16-bit.
REQ-009 actbuf_wr_vld  in  1  actbuf_wr_data valid this cycle.
REQ-010 actbuf_wr_req  out  1  block is requesting activation words.
REQ-011 sblk_status  out  1  one-cycle tile-done pulse.
REQ-012 pbuf_rd_data  out  32  partial-sum output stream.

Function
REQ-013 Config: P0=KW kernel width, P1=OW outputs per tile, P2=stride, P3 reserved (latched, no effect), P4..P7 tile-loop counts; P0, P1, P2 of 0 are treated as 1.
REQ-014 Derived: W=(OW-1)*stride+KW words per tile, required W<=64 (buffer index wraps mod 64 otherwise); tiles T=P4*P5*P6*P7 (a zero factor counts as 1).
REQ-015 States IDLE, LOAD, MAC, OUT; reset state IDLE.
REQ-016 temp_param_en=1 in any state latches temp_param, clears all counters, enters LOAD next cycle; this overrides every other transition.
REQ-017 actbuf_wr_req = (state==LOAD) && (wr_cnt + actbuf_wr_vld < W), combinational.
REQ-018 In LOAD, every cycle with actbuf_wr_vld=1 and wr_cnt<W writes actbuf_wr_data to buffer[wr_cnt] and increments wr_cnt; vld with wr_cnt==W, or outside LOAD, is ignored.
REQ-019 Gaps in actbuf_wr_vld are legal and change no result; the source may assert vld one cycle after sampling req.
REQ-020 LOAD->MAC the cycle after wr_cnt reaches W.
REQ-021 MAC: one product per cycle, OW*KW cycles, order o outer, k inner; psum[o] = sum over k of act_hi*act_lo of buffer[o*stride+k]; signed 16x16 product, 32-bit two's-complement accumulation, wrap on overflow.
REQ-022 MAC->OUT after the last product; OUT lasts OW cycles, pbuf_rd_data = psum[o] in OUT cycle o (o=0..OW-1); pbuf_rd_data = 0 in all other states.
REQ-023 After last OUT cycle: tile_cnt increments; if tile_cnt<T, go to LOAD with wr_cnt=0, else go to IDLE.
REQ-024 sblk_status is registered, high exactly one cycle: the first cycle after leaving OUT.
REQ-025 In IDLE, actbuf_wr_req=0 and data is ignored until temp_param_en.

Reset
REQ-026 rst_n low asynchronously forces: state IDLE, all counters 0, config 0, psums 0, actbuf_wr_req=0, sblk_status=0, pbuf_rd_data=0.
REQ-027 Reset asserted mid-operation discards the partial tile; after release the block waits in IDLE for temp_param_en.
REQ-028 Buffer contents need no reset.

Verification
REQ-029 Config P0..P7=4,7,2,8,8,7,2,4; 16 words {16'h0001,16'h0002} -> req drops after the 16th word; 28 MAC cycles; pbuf_rd_data = 8 for 7 cycles; then one sblk_status pulse; req reasserts.
REQ-030 Same config, word i={i,1} (i=0..15) -> pbuf_rd_data sequence 6,14,22,30,38,46,54.
REQ-031 Same stream with vld pattern 5 words, 5-cycle gap, repeat -> identical outputs to REQ-030; no word lost or duplicated.
REQ-032 All words {16'hffff,16'hffff} -> every psum = 4 (products of -1*-1).
REQ-033 P4..P7=1,1,1,1 -> exactly one sblk_status pulse, then IDLE with req=0 even if vld continues.
REQ-034 rst_n low after 10 of 16 words, release, reload config -> req high, fresh tile needs all 16 words, results as REQ-030.
